// File: rtl/xor32_pkg.sv
// rtl/xor32_pkg.sv - shared types, default seeds and xorshift128 step functions
package xor32_pkg;

   typedef logic [127:0] xor32_state_t;

   typedef enum logic {
      ST_SEED,
      ST_RUN
   } xor32_gen_state_t;

   localparam logic [31:0] XOR32_SEED0 = 32'd123456789;
   localparam logic [31:0] XOR32_SEED1 = 32'd362436069;
   localparam logic [31:0] XOR32_SEED2 = 32'd521288629;
   localparam logic [31:0] XOR32_SEED3 = 32'd88675123;

   localparam int XOR32_SHL_T = 11;
   localparam int XOR32_SHR_W = 19;
   localparam int XOR32_SHR_T = 8;

   // State packs {w,z,y,x} with x in the low word; one step shifts the words down
   function automatic xor32_state_t xor32_step(input xor32_state_t s);
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      logic [31:0] w;
      logic [31:0] t;
      logic [31:0] nw;
      x  = s[31:0];
      y  = s[63:32];
      z  = s[95:64];
      w  = s[127:96];
      t  = x ^ (x << XOR32_SHL_T);
      nw = w ^ (w >> XOR32_SHR_W) ^ t ^ (t >> XOR32_SHR_T);
      return {nw, w, z, y};
   endfunction

   function automatic xor32_state_t xor32_step4(input xor32_state_t s);
      xor32_state_t r;
      r = s;
      for (int i = 0; i < 4; i++) begin
         r = xor32_step(r);
      end
      return r;
   endfunction

endpackage

// File: rtl/xor32_stream_generator_if.sv
// rtl/xor32_stream_generator_if.sv - random stream, reseed and status bundle
interface xor32_stream_generator_if #(
   parameter int SIZE = 8
);
   logic                 iReseed;
   logic [127:0]         iSeed;
   logic                 oValid;
   logic                 iReady;
   logic [SIZE*32-1:0]   oRandom;
   logic                 oSeeding;

   modport master (
      input  iReseed,
      input  iSeed,
      output oValid,
      input  iReady,
      output oRandom,
      output oSeeding
   );

   modport slave (
      output iReseed,
      output iSeed,
      input  oValid,
      output iReady,
      input  oRandom,
      input  oSeeding
   );
endinterface

// File: rtl/xor32_lane.sv
// rtl/xor32_lane.sv - one 128-bit xorshift128 lane with load and step enables
module xor32_lane
   import xor32_pkg::*;
(
   input  logic          clk,
   input  logic          load,
   input  xor32_state_t  value,
   input  logic          step,
   output logic [31:0]   w
);

   xor32_state_t st;

   // No reset: the seeding sequence overwrites every lane before it is observed
   always_ff @(posedge clk) begin
      if (load) begin
         st <= value;
      end else if (step) begin
         st <= xor32_step(st);
      end
   end

   assign w = st[127:96];

endmodule

// File: rtl/xor32_stream_generator.sv
// rtl/xor32_stream_generator.sv - multi-lane xorshift128 valid/ready random source
module xor32_stream_generator
   import xor32_pkg::*;
#(
   parameter int          SIZE  = 8,
   parameter logic [31:0] SEED0 = XOR32_SEED0,
   parameter logic [31:0] SEED1 = XOR32_SEED1,
   parameter logic [31:0] SEED2 = XOR32_SEED2,
   parameter logic [31:0] SEED3 = XOR32_SEED3
) (
   input  logic                       iClock,
   input  logic                       iReset,
   xor32_stream_generator_if.master   bus
);

   localparam int                 CNT_W        = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [CNT_W-1:0]   LAST_CNT     = CNT_W'(SIZE - 1);
   localparam xor32_state_t       DEFAULT_SEED = {SEED3, SEED2, SEED1, SEED0};

   xor32_gen_state_t  state_q;
   xor32_gen_state_t  state_d;
   xor32_state_t      c_q;
   xor32_state_t      c_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              valid_q;
   logic              valid_d;

   logic              seed_load;
   logic              lane_step;
   logic [31:0]       lane_w [SIZE];

   // A reseed in the same cycle as a handshake consumes the word but never steps
   assign seed_load = (state_q == ST_SEED) && !iReset && !bus.iReseed;
   assign lane_step = (state_q == ST_RUN) && valid_q && bus.iReady
                      && !iReset && !bus.iReseed;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q <= ST_SEED;
         c_q     <= DEFAULT_SEED;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (bus.iReseed) begin
         state_d = ST_SEED;
         cnt_d   = '0;
         valid_d = 1'b0;
         c_d     = (bus.iSeed == '0) ? DEFAULT_SEED : bus.iSeed;
      end else begin
         case (state_q)
            ST_SEED: begin
               c_d   = xor32_step4(c_q);
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_RUN;
                  valid_d = 1'b1;
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_SEED;
               cnt_d   = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   for (genvar k = 0; k < SIZE; k++) begin : g_lane
      xor32_lane u_lane (
         .clk   (iClock),
         .load  (seed_load && (cnt_q == CNT_W'(k))),
         .value (c_q),
         .step  (lane_step),
         .w     (lane_w[k])
      );
      assign bus.oRandom[k*32 +: 32] = lane_w[k];
   end

   assign bus.oValid   = valid_q;
   assign bus.oSeeding = (state_q == ST_SEED);

endmodule

// File: tb/tb_xor32_stream_generator.sv
// tb/tb_xor32_stream_generator.sv - scoreboard and vector bench for xor32_stream_generator
module tb_xor32_stream_generator;

   localparam int SIZE = 8;
   localparam logic [127:0] DEF = {32'd88675123, 32'd521288629, 32'd362436069, 32'd123456789};

   typedef logic [SIZE*32-1:0] word_t;

   typedef struct {
      logic        rdy;
      logic [31:0] lane0;
      logic        chk1;
      logic [31:0] lane1;
   } vec_t;

   logic iClock = 1'b0;
   logic iReset = 1'b0;

   xor32_stream_generator_if #(.SIZE(SIZE)) bus();

   xor32_stream_generator #(.SIZE(SIZE)) dut (
      .iClock (iClock),
      .iReset (iReset),
      .bus    (bus)
   );

   always #5 iClock = ~iClock;

   int           checks = 0;
   int           errors = 0;
   word_t        exp_q[$];
   logic [127:0] m_base;
   int           m_n;
   int           m_cnt;
   logic         m_valid;
   bit           known = 1'b0;
   vec_t         vt[5];
   logic [127:0] s1;
   logic [127:0] s2;
   logic [127:0] s3;

   function automatic logic [127:0] ref_step(input logic [127:0] s);
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] t;
      a = s[31:0];
      d = s[127:96];
      t = a ^ {a[20:0], 11'b0};
      return {d ^ {19'b0, d[31:19]} ^ t ^ {8'b0, t[31:8]}, s[127:32]};
   endfunction

   function automatic word_t model_word(input logic [127:0] b, input int n);
      word_t        r;
      logic [127:0] s;
      r = '0;
      for (int k = 0; k < SIZE; k++) begin
         s = b;
         for (int j = 0; j < 4*k + n; j++) s = ref_step(s);
         r[k*32 +: 32] = s[127:96];
      end
      return r;
   endfunction

   task automatic check(input string name, input word_t act, input word_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic rst, input logic rdy, input logic rs, input logic [127:0] sd);
      if (known) begin
         check("valid", word_t'(bus.oValid), word_t'(m_valid));
         check("seeding", word_t'(bus.oSeeding), word_t'(!m_valid));
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_empty: got empty queue expected a word");
            end else begin
               check("word", bus.oRandom, exp_q[0]);
            end
         end
      end
      iReset      = rst;
      bus.iReady  = rdy;
      bus.iReseed = rs;
      bus.iSeed   = sd;
      @(posedge iClock);
      #1;
      iReset      = 1'b0;
      bus.iReseed = 1'b0;
      if (rst) begin
         m_cnt = 0; m_valid = 1'b0; m_base = DEF; exp_q.delete(); known = 1'b1;
      end else if (rs) begin
         m_cnt = 0; m_valid = 1'b0; m_base = (sd == '0) ? DEF : sd; exp_q.delete();
      end else if (!m_valid) begin
         m_cnt++;
         if (m_cnt == SIZE) begin
            m_valid = 1'b1;
            m_n = 0;
            exp_q.push_back(model_word(m_base, 0));
         end
      end else if (rdy) begin
         void'(exp_q.pop_front());
         m_n++;
         exp_q.push_back(model_word(m_base, m_n));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0] = '{rdy: 1'b1, lane0: 32'd88675123,   chk1: 1'b1, lane1: 32'd3633119408};
      vt[1] = '{rdy: 1'b1, lane0: 32'd3701687786, chk1: 1'b0, lane1: 32'd0};
      vt[2] = '{rdy: 1'b1, lane0: 32'd458299110,  chk1: 1'b0, lane1: 32'd0};
      vt[3] = '{rdy: 1'b0, lane0: 32'd2500872618, chk1: 1'b0, lane1: 32'd0};
      vt[4] = '{rdy: 1'b0, lane0: 32'd2500872618, chk1: 1'b0, lane1: 32'd0};
      s1 = 128'hdeadbeef_01234567_89abcdef_0badf00d;
      s2 = 128'h11111111_22222222_33333333_44444444;
      s3 = 128'h00000000_00000000_00000000_00000001;

      bus.iReady = 1'b0; bus.iReseed = 1'b0; bus.iSeed = '0;
      cyc(1'b1, 1'b0, 1'b0, '0);
      // iReady during seeding must be ignored
      for (int i = 0; i < SIZE; i++) cyc(1'b0, (i == 3), 1'b0, '0);

      for (int i = 0; i < 5; i++) begin
         check("tbl_lane0", word_t'(bus.oRandom[31:0]), word_t'(vt[i].lane0));
         if (vt[i].chk1) check("tbl_lane1", word_t'(bus.oRandom[63:32]), word_t'(vt[i].lane1));
         cyc(1'b0, vt[i].rdy, 1'b0, '0);
      end

      cyc(1'b0, 1'b1, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b1, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b0, '0);

      cyc(1'b0, 1'b0, 1'b1, '0);
      for (int i = 0; i < SIZE; i++) cyc(1'b0, 1'b0, 1'b0, '0);
      check("zero_seed_lane0", word_t'(bus.oRandom[31:0]), word_t'(32'd88675123));
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0);

      cyc(1'b0, 1'b1, 1'b1, s1);
      for (int i = 0; i < SIZE; i++) cyc(1'b0, 1'b1, 1'b0, '0);
      check("reseed_lane0", word_t'(bus.oRandom[31:0]), word_t'(s1[127:96]));
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0);

      for (int i = 0; i < 20; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);

      cyc(1'b0, 1'b0, 1'b1, s2);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b1, s3);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b1, s2);
      for (int i = 0; i < SIZE; i++) cyc(1'b0, 1'b0, 1'b0, '0);
      check("post_reset_lane0", word_t'(bus.oRandom[31:0]), word_t'(32'd88675123));
      check("post_reset_lane1", word_t'(bus.oRandom[63:32]), word_t'(32'd3633119408));
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
